// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared encodings for the instruction-driven datapath controller.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Instruction op field [15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;
  localparam logic [3:0] OP_MOVI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes driven on opcode
  localparam logic [7:0] ALU_AND = 8'h01;
  localparam logic [7:0] ALU_OR  = 8'h02;
  localparam logic [7:0] ALU_XOR = 8'h03;
  localparam logic [7:0] ALU_ADD = 8'h05;
  localparam logic [7:0] ALU_SUB = 8'h09;
  localparam logic [7:0] ALU_MOV = 8'h0D;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Datapath control bundle, registered as one unit in the sequencer
  typedef struct packed {
    logic [15:0] immediate;
    logic [15:0] enable;
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic        imm_control;
    logic [7:0]  opcode;
    logic        buff_en;
  } ctrl_bundle_t;

  // Mux select for register Rn is n+1 so that 0 can mean "no operand"
  function automatic logic [4:0] mux_sel(input logic [3:0] r);
    return {1'b0, r} + 5'd1;
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purpose: pure decode of one 16-bit instruction word into the datapath control bundle.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the input word continuously.
module instr_decode_comb
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         is_halt,
  output logic         illegal
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;

  assign op = instr[15:12];
  assign rd = instr[11:8];
  assign ra = instr[7:4];
  assign rb = instr[3:0];

  // Map the op field onto enables, mux selects, immediate and ALU code
  always_comb begin
    bundle  = '0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP: begin
        // all-zero bundle: no write, ALU output not driven
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        bundle.enable   = 16'b1 << rd;
        bundle.control1 = mux_sel(ra);
        bundle.control2 = mux_sel(rb);
        bundle.buff_en  = 1'b1;
        case (op)
          OP_ADD:  bundle.opcode = ALU_ADD;
          OP_SUB:  bundle.opcode = ALU_SUB;
          OP_AND:  bundle.opcode = ALU_AND;
          OP_OR:   bundle.opcode = ALU_OR;
          default: bundle.opcode = ALU_XOR;
        endcase
      end
      OP_ADDI, OP_SUBI, OP_MOVI: begin
        bundle.immediate   = {{8{instr[7]}}, instr[7:0]};
        bundle.enable      = 16'b1 << rd;
        bundle.imm_control = 1'b1;
        bundle.buff_en     = 1'b1;
        // MOVI ignores the left operand, so its left mux is left unselected
        bundle.control1    = (op == OP_MOVI) ? 5'd0 : mux_sel(rd);
        case (op)
          OP_ADDI: bundle.opcode = ALU_ADD;
          OP_SUBI: bundle.opcode = ALU_SUB;
          default: bundle.opcode = ALU_MOV;
        endcase
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_seq.sv
// Purpose: fetch/decode/execute sequencer driving the 16-bit datapath control bundle.
// Latency: instr accept -> EXEC bundle 2 cycles; 3 cycles per instruction with zero-wait memory.
// Backpressure: fetch_req and pc hold until instr_valid; TIMEOUT waiting cycles -> HALT, fault 10.
module instr_decode_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic [15:0]       immediate,
  output logic [15:0]       enable,
  output logic [4:0]        control1,
  output logic [4:0]        control2,
  output logic              imm_control,
  output logic [7:0]        opcode,
  output logic              buff_en,
  output logic              busy,
  output logic [1:0]        fault
);

  // Last waiting-cycle count before the fetch is abandoned
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [2:0]   state;
  logic [3:0]   wait_cnt;
  logic [15:0]  instr_q;
  ctrl_bundle_t bundle_q;
  ctrl_bundle_t dec_bundle;
  logic         dec_halt;
  logic         dec_illegal;

  instr_decode_comb u_decode (
    .instr   (instr_q),
    .bundle  (dec_bundle),
    .is_halt (dec_halt),
    .illegal (dec_illegal)
  );

  // Sequencer: state, pc, fetch timeout, latched word, fault and the output bundle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      wait_cnt <= '0;
      instr_q  <= '0;
      bundle_q <= '0;
      fault    <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state    <= ST_FETCH;
            pc       <= '0;
            wait_cnt <= '0;
            fault    <= FAULT_NONE;
          end
        end
        ST_FETCH: begin
          if (instr_valid) begin
            instr_q  <= instr;
            wait_cnt <= '0;
            state    <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            fault    <= FAULT_TIMEOUT;
            state    <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            fault <= FAULT_ILLEGAL;
            state <= ST_HALT;
          end else if (dec_halt) begin
            state <= ST_HALT;
          end else begin
            // bundle becomes visible during EXEC only
            bundle_q <= dec_bundle;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bundle_q <= '0;
          pc       <= pc + ADDR_W'(1);
          state    <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status follow the state directly so reset clears them at once
  always_comb begin
    fetch_req = (state == ST_FETCH);
    busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  end

  assign immediate   = bundle_q.immediate;
  assign enable      = bundle_q.enable;
  assign control1    = bundle_q.control1;
  assign control2    = bundle_q.control2;
  assign imm_control = bundle_q.imm_control;
  assign opcode      = bundle_q.opcode;
  assign buff_en     = bundle_q.buff_en;

endmodule
